alu_acc_seq: RTL and testbench

//  Accumulator/carry sequencer feeding alu_add (no carry-in). Holds the 4004-style accumulator (ACC) and carry (CY).

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_daa_detect.sv | 18 +
 rtl/alu_acc_seq.sv | 157 +++++++++++++++
 tb/tb_alu_acc_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator/carry sequencer.
//   - op_code encodings for adder ops and register-only ops
//   - sequencer state encoding
//   - decimal-adjust constants
//   - helpers that classify an op by the number of adder passes it needs
package alu_pkg;

   localparam logic [3:0] ADD = 4'd0;
   localparam logic [3:0] SUB = 4'd1;
   localparam logic [3:0] IAC = 4'd2;
   localparam logic [3:0] DAC = 4'd3;
   localparam logic [3:0] DAA = 4'd4;
   localparam logic [3:0] CLC = 4'd5;
   localparam logic [3:0] STC = 4'd6;
   localparam logic [3:0] CMC = 4'd7;
   localparam logic [3:0] CMA = 4'd8;
   localparam logic [3:0] RAL = 4'd9;
   localparam logic [3:0] RAR = 4'd10;
   localparam logic [3:0] LD  = 4'd11;
   localparam logic [3:0] CLB = 4'd12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS1 = 2'd1,
      PASS2 = 2'd2
   } state_t;

   localparam int DAA_THRESH = 9;
   localparam int DAA_ADJ    = 6;

   // ADD/SUB must fold the old carry in with a second pass because the
   // external adder has no carry-in.
   function automatic logic is_two_pass(input logic [3:0] op);
      return (op == ADD) || (op == SUB);
   endfunction

   function automatic logic is_one_pass(input logic [3:0] op);
      return (op == IAC) || (op == DAC) || (op == DAA);
   endfunction

endpackage

// File: rtl/alu_daa_detect.sv
// Decimal-adjust detector.
//   acc    in  WORD_WIDTH  current accumulator
//   cy     in  1           current carry
//   adjust out WORD_WIDTH  value to add: DAA_ADJ when acc exceeds DAA_THRESH
//                          or carry is set, otherwise zero
module alu_daa_detect
   import alu_pkg::*;
#(
   parameter int WORD_WIDTH = 4
) (
   input  logic [WORD_WIDTH-1:0] acc,
   input  logic                  cy,
   output logic [WORD_WIDTH-1:0] adjust
);

   assign adjust = ((int'(acc) > DAA_THRESH) || cy) ? WORD_WIDTH'(DAA_ADJ) : '0;

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator/carry sequencer driving an external carry-less adder.
// Holds ACC and CY, runs adder ops in one or two passes, and executes
// register-only ops directly at the accept edge.
//   clk, rst         clock; asynchronous active-high reset
//   op_valid/ready   op handshake (accept when both high at a rising edge)
//   op_code, op_r    operation and register operand, latched at accept
//   add_a, add_b     adder operands (combinational, zero when idle)
//   add_sum,add_cout adder result
//   acc, cy          registered accumulator and carry
//   done             one-cycle pulse after an op commits
module alu_acc_seq
   import alu_pkg::*;
#(
   parameter int WORD_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [3:0]            op_code,
   input  logic [WORD_WIDTH-1:0] op_r,
   output logic [WORD_WIDTH-1:0] add_a,
   output logic [WORD_WIDTH-1:0] add_b,
   input  logic [WORD_WIDTH-1:0] add_sum,
   input  logic                  add_cout,
   output logic [WORD_WIDTH-1:0] acc,
   output logic                  cy,
   output logic                  done
);

   state_t                  state_q, state_d;
   logic [WORD_WIDTH-1:0]   acc_q, acc_d;
   logic                    cy_q, cy_d;
   logic [WORD_WIDTH-1:0]   t_q, t_d;      // first-pass sum
   logic                    c1_q, c1_d;    // first-pass carry
   logic [3:0]              op_q, op_d;
   logic [WORD_WIDTH-1:0]   r_q, r_d;
   logic                    done_q, done_d;
   logic [WORD_WIDTH-1:0]   daa_adj;

   alu_daa_detect #(.WORD_WIDTH(WORD_WIDTH)) u_daa (
      .acc    (acc_q),
      .cy     (cy_q),
      .adjust (daa_adj)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cy_q    <= 1'b0;
         t_q     <= '0;
         c1_q    <= 1'b0;
         op_q    <= '0;
         r_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cy_q    <= cy_d;
         t_q     <= t_d;
         c1_q    <= c1_d;
         op_q    <= op_d;
         r_q     <= r_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cy_d    = cy_q;
      t_d     = t_q;
      c1_d    = c1_q;
      op_d    = op_q;
      r_d     = r_q;
      done_d  = 1'b0;
      add_a   = '0;
      add_b   = '0;

      case (state_q)
         IDLE: begin
            if (op_valid) begin
               op_d = op_code;
               r_d  = op_r;
               if (is_two_pass(op_code) || is_one_pass(op_code)) begin
                  state_d = PASS1;
               end else begin
                  // Register ops (and undefined codes) commit right here.
                  done_d = 1'b1;
                  case (op_code)
                     CLC:     cy_d = 1'b0;
                     STC:     cy_d = 1'b1;
                     CMC:     cy_d = ~cy_q;
                     CMA:     acc_d = ~acc_q;
                     RAL:     {cy_d, acc_d} = {acc_q, cy_q};
                     RAR:     {acc_d, cy_d} = {cy_q, acc_q};
                     LD:      acc_d = op_r;
                     CLB: begin
                        acc_d = '0;
                        cy_d  = 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
         end

         PASS1: begin
            add_a = acc_q;
            case (op_q)
               ADD, SUB: begin
                  // SUB adds the one's complement; the carry pass supplies the +1.
                  add_b   = (op_q == SUB) ? ~r_q : r_q;
                  t_d     = add_sum;
                  c1_d    = add_cout;
                  state_d = PASS2;
               end
               IAC, DAC: begin
                  add_b   = (op_q == IAC) ? WORD_WIDTH'(1) : '1;
                  acc_d   = add_sum;
                  cy_d    = add_cout;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
               DAA: begin
                  // DAA can set the carry but never clears it.
                  add_b   = daa_adj;
                  acc_d   = add_sum;
                  cy_d    = cy_q | add_cout;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end

         PASS2: begin
            // Only one of the two passes can carry, so OR-ing them is exact.
            add_a   = t_q;
            add_b   = {{(WORD_WIDTH-1){1'b0}}, cy_q};
            acc_d   = add_sum;
            cy_d    = c1_q | add_cout;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign op_ready = (state_q == IDLE);
   assign acc      = acc_q;
   assign cy       = cy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
module tb_alu_acc_seq;
   import alu_pkg::*;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         op_valid;
   logic         op_ready;
   logic [3:0]   op_code;
   logic [W-1:0] op_r;
   logic [W-1:0] add_a, add_b, add_sum;
   logic         add_cout;
   logic [W-1:0] acc;
   logic         cy;
   logic         done;
   logic [W:0]   add_full;

   alu_acc_seq #(.WORD_WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .op_r     (op_r),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .acc      (acc),
      .cy       (cy),
      .done     (done)
   );

   // Stand-in for the parent's carry-less adder.
   assign add_full = {1'b0, add_a} + {1'b0, add_b};
   assign add_sum  = add_full[W-1:0];
   assign add_cout = add_full[W];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_acc_q[$];
   int exp_cy_q[$];
   int m_acc = 0;
   int m_cy  = 0;
   int mon_acc, mon_cy;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference model: 4004 semantics in plain integer arithmetic.
   task automatic apply_model(input logic [3:0] op, input int r);
      int full;
      case (op)
         ADD: begin full = m_acc + r + m_cy;        m_acc = full % 16; m_cy = (full >= 16) ? 1 : 0; end
         SUB: begin full = m_acc + (15 - r) + m_cy; m_acc = full % 16; m_cy = (full >= 16) ? 1 : 0; end
         IAC: begin full = m_acc + 1;               m_acc = full % 16; m_cy = (full >= 16) ? 1 : 0; end
         DAC: begin full = m_acc + 15;              m_acc = full % 16; m_cy = (full >= 16) ? 1 : 0; end
         DAA: begin
            if (m_acc > 9 || m_cy == 1) begin
               full  = m_acc + 6;
               m_acc = full % 16;
               if (full >= 16) m_cy = 1;
            end
         end
         CLC: m_cy = 0;
         STC: m_cy = 1;
         CMC: m_cy = 1 - m_cy;
         CMA: m_acc = 15 - m_acc;
         RAL: begin full = m_acc * 2 + m_cy; m_acc = full % 16; m_cy = full / 16; end
         RAR: begin full = m_cy * 16 + m_acc; m_acc = full / 2; m_cy = full % 2; end
         LD:  m_acc = r;
         CLB: begin m_acc = 0; m_cy = 0; end
         default: ;
      endcase
      exp_acc_q.push_back(m_acc);
      exp_cy_q.push_back(m_cy);
   endtask

   // Called at a falling edge; returns at the falling edge after the accept edge
   // with op_valid still high.
   task automatic issue(input logic [3:0] op, input logic [3:0] r);
      int n;
      n = 0;
      op_valid = 1'b1;
      op_code  = op;
      op_r     = r;
      while (!op_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!op_ready) begin
         chk("accept_timeout", 0, 1);
         op_valid = 1'b0;
      end else begin
         apply_model(op, int'(r));
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      op_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_acc_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            mon_acc = exp_acc_q.pop_front();
            mon_cy  = exp_cy_q.pop_front();
            chk("acc", int'(acc), mon_acc);
            chk("cy", int'(cy), mon_cy);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; op_valid = 1'b0; op_code = '0; op_r = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_acc", int'(acc), 0);
      chk("rst_cy", int'(cy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_ready", int'(op_ready), 1);
      chk("rst_add_a", int'(add_a), 0);
      chk("rst_add_b", int'(add_b), 0);
      rst = 1'b0;
      @(negedge clk);

      // ADD 7+9+1 with next op held during the passes
      issue(LD, 4'd7);
      issue(STC, 4'd0);
      issue(ADD, 4'd9);
      chk("add_p1_ready", int'(op_ready), 0);
      chk("add_p1_a", int'(add_a), 7);
      chk("add_p1_b", int'(add_b), 9);
      op_code = IAC; op_r = 4'd0;
      @(negedge clk);
      chk("add_p2_ready", int'(op_ready), 0);
      chk("add_p2_done", int'(done), 0);
      chk("add_p2_a", int'(add_a), 0);
      chk("add_p2_b", int'(add_b), 1);
      @(negedge clk);
      chk("add_done", int'(done), 1);
      chk("add_done_ready", int'(op_ready), 1);
      chk("add_acc", int'(acc), 1);
      chk("add_cy", int'(cy), 1);
      issue(IAC, 4'd0);
      idle(3);

      // SUB cases
      issue(LD, 4'd5); issue(STC, 4'd0); issue(SUB, 4'd3); idle(3);
      chk("sub1_acc", int'(acc), 2);
      chk("sub1_cy", int'(cy), 1);
      issue(LD, 4'd5); issue(CLC, 4'd0); issue(SUB, 4'd3); idle(3);
      chk("sub2_acc", int'(acc), 1);
      chk("sub2_cy", int'(cy), 1);
      issue(LD, 4'd2); issue(STC, 4'd0); issue(SUB, 4'd5); idle(3);
      chk("sub3_acc", int'(acc), 13);
      chk("sub3_cy", int'(cy), 0);

      // DAA cases and IAC wrap
      issue(LD, 4'hB); issue(CLC, 4'd0); issue(DAA, 4'd0); idle(2);
      chk("daa1_acc", int'(acc), 1);
      chk("daa1_cy", int'(cy), 1);
      issue(LD, 4'd4); issue(CLC, 4'd0); issue(DAA, 4'd0);
      chk("daa2_add_a", int'(add_a), 4);
      chk("daa2_add_b", int'(add_b), 0);
      idle(2);
      chk("daa2_acc", int'(acc), 4);
      chk("daa2_cy", int'(cy), 0);
      issue(LD, 4'd2); issue(STC, 4'd0); issue(DAA, 4'd0); idle(2);
      chk("daa3_acc", int'(acc), 8);
      chk("daa3_cy", int'(cy), 1);
      issue(LD, 4'd15); issue(CLC, 4'd0); issue(IAC, 4'd0); idle(2);
      chk("iac_acc", int'(acc), 0);
      chk("iac_cy", int'(cy), 1);

      // Register ops back-to-back
      issue(LD, 4'd8);
      issue(STC, 4'd0);
      chk("b2b_ready1", int'(op_ready), 1);
      issue(RAL, 4'd0);
      chk("b2b_ready2", int'(op_ready), 1);
      chk("ral_acc", int'(acc), 1);
      chk("ral_cy", int'(cy), 1);
      issue(CMA, 4'd0);
      chk("b2b_ready3", int'(op_ready), 1);
      chk("cma_acc", int'(acc), 14);
      issue(CLB, 4'd0);
      chk("clb_acc", int'(acc), 0);
      chk("clb_cy", int'(cy), 0);
      idle(2);

      // Reset during PASS1 of ADD
      issue(LD, 4'd5);
      issue(ADD, 4'd3);
      op_valid = 1'b0;
      rst = 1'b1;
      void'(exp_acc_q.pop_back());
      void'(exp_cy_q.pop_back());
      m_acc = 0; m_cy = 0;
      @(negedge clk);
      chk("mid_rst_acc", int'(acc), 0);
      chk("mid_rst_cy", int'(cy), 0);
      chk("mid_rst_done", int'(done), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", int'(op_ready), 1);
      chk("mid_rst_add_a", int'(add_a), 0);
      chk("mid_rst_add_b", int'(add_b), 0);
      chk("mid_rst_no_done", int'(done), 0);
      idle(3);

      // Random ops including undefined codes
      repeat (300) begin
         issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(10);
      chk("scoreboard_empty", exp_acc_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
